// File: rtl/jt12_wrseq_if.sv
// Host request channel plus chip-side register bus of the write sequencer.
interface jt12_wrseq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_part;
  logic [7:0] req_reg;
  logic [7:0] req_val;
  logic [1:0] addr;
  logic [7:0] dout;
  logic       write;
  logic       busy;
  logic       fifo_empty;
  logic       idle;
  logic       timeout;

  // Sequencer side: consumes requests and the busy flag, drives the chip bus.
  modport slave (
    input  req_valid, req_part, req_reg, req_val, busy,
    output req_ready, addr, dout, write, fifo_empty, idle, timeout
  );

  // Host / chip side: produces requests and busy, observes the bus.
  modport master (
    output req_valid, req_part, req_reg, req_val, busy,
    input  req_ready, addr, dout, write, fifo_empty, idle, timeout
  );
endinterface

// File: rtl/jt12_wrseq.sv
// Queued register-write sequencer for a YM2612-style chip: each request
// becomes an address strobe, a fixed idle gap, a data strobe, then a wait
// for the chip busy flag to rise and fall (with a bounded timeout).
module jt12_wrseq #(
  parameter int DEPTH   = 4,
  parameter int GAP     = 2,
  parameter int BUSY_TO = 1023
) (
  input logic         clk,
  input logic         rst,
  jt12_wrseq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [9:0]    TO_LIMIT = 10'(BUSY_TO);
  localparam logic [9:0]    BH_LIMIT = 10'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP, S_DATA, S_BUSYHI, S_BUSYLO
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [9:0]    bcnt_q, bcnt_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   head;
  logic          full, empty, push, pop;
  logic          wr_strobe, to_pulse;

  // A full FIFO refuses pushes even when the sequencer pops that same cycle.
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign push  = bus.req_valid && !full;
  assign pop   = (state_q == S_DATA);
  assign head  = mem_q[rd_ptr_q];

  // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Entry storage {part, reg, val}; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.req_part, bus.req_reg, bus.req_val};
  end

  // Control and bus-hold registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      bcnt_q   <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      bcnt_q   <= bcnt_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
    end
  end

  // Next-state logic; bcnt is shared by the busy-rise and busy-fall waits.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (GAP == 0) begin
          state_d = S_DATA;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_DATA;
        else             gap_d   = gap_q - GW'(1);
      end
      S_DATA: begin
        state_d = S_BUSYHI;
        bcnt_d  = '0;
      end
      S_BUSYHI: begin
        if (bus.busy) begin
          state_d = S_BUSYLO;
          bcnt_d  = '0;
        end else if (bcnt_q == BH_LIMIT) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d  = bcnt_q + 10'd1;
        end
      end
      S_BUSYLO: begin
        if (!bus.busy || (bcnt_q == TO_LIMIT)) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end else begin
          bcnt_d  = bcnt_q + 10'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs: strobes only in ADDR/DATA, address and data held otherwise.
  always_comb begin
    wr_strobe = 1'b0;
    to_pulse  = 1'b0;
    addr_d    = addr_q;
    dout_d    = dout_q;
    unique case (state_q)
      S_ADDR: begin
        wr_strobe = 1'b1;
        addr_d    = {head[16], 1'b0};
        dout_d    = head[15:8];
      end
      S_DATA: begin
        wr_strobe = 1'b1;
        addr_d    = {head[16], 1'b1};
        dout_d    = head[7:0];
      end
      S_BUSYLO: begin
        to_pulse  = bus.busy && (bcnt_q == TO_LIMIT);
      end
      default: begin
        wr_strobe = 1'b0;
      end
    endcase
  end

  assign bus.write      = wr_strobe;
  assign bus.addr       = addr_d;
  assign bus.dout       = dout_d;
  assign bus.timeout    = to_pulse;
  assign bus.req_ready  = !full;
  assign bus.fifo_empty = empty;
  assign bus.idle       = empty && (state_q == S_IDLE);

endmodule
